// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage and its IF/ID boundary.
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, DROP, FULL} fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/ack channel; the fetch stage is the master.
interface instruction_fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;

  modport master (output ImemReq, ImemAddr, input ImemAck, ImemData);
  modport slave  (input ImemReq, ImemAddr, output ImemAck, ImemData);
endinterface

// File: rtl/instruction_fetch_stage_skid.sv
// One-entry holding register for a word that returned while decode was stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic  Clk,
  input  logic  Reset,
  input  logic  load_i,
  input  logic  unload_i,
  input  logic  clear_i,
  input  ifid_t d_i,
  output ifid_t q_o,
  output logic  valid_o
);
  ifid_t data_q;
  logic  valid_q;

  always_ff @(posedge Clk) begin
    if (Reset || clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '{instr: NOP_INSTR, pc4: 32'h0};
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, imem handshake, IF/ID latch, stall skid and redirect flush.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Stall,
  input  logic                        Redirect,
  input  logic [31:0]                 RedirectPC,
  instruction_fetch_stage_if.master   imem,
  output logic                        IfIdValid,
  output logic [31:0]                 IfIdInstr,
  output logic [31:0]                 IfIdPCPlus4,
  output logic [15:0]                 Imm16
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, tgt_q, tgt_d;
  logic         valid_q, valid_d;
  ifid_t        ifid_q, ifid_d, skid_q;
  logic         skid_load, skid_unload, skid_clear, skid_vld;
  logic         latch_free, consume, ack;
  logic [31:0]  pc_next, rpc;

  assign ack        = imem.ImemAck;
  assign latch_free = ~valid_q | ~Stall;
  assign consume    = valid_q & ~Stall;
  assign pc_next    = pc_q + PC_STEP;
  assign rpc        = RedirectPC & ~32'h3;

  fetch_skid_buffer u_skid (
    .Clk      (Clk),
    .Reset    (Reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .d_i      ('{instr: imem.ImemData, pc4: pc_next}),
    .q_o      (skid_q),
    .valid_o  (skid_vld)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    valid_d     = valid_q;
    ifid_d      = ifid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (Redirect) begin
      // A word already in flight cannot be cancelled; DROP waits it out.
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      unique case (state_q)
        FETCH: if (ack) pc_d = rpc;
               else begin tgt_d = rpc; state_d = DROP; end
        DROP:  if (ack) begin pc_d = rpc; state_d = FETCH; end
               else tgt_d = rpc;
        FULL:  begin pc_d = rpc; state_d = FETCH; end
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack && latch_free) begin
            ifid_d  = '{instr: imem.ImemData, pc4: pc_next};
            valid_d = 1'b1;
            pc_d    = pc_next;
          end else if (ack) begin
            skid_load = 1'b1;
            pc_d      = pc_next;
            state_d   = FULL;
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        DROP: begin
          if (consume) valid_d = 1'b0;
          if (ack) begin pc_d = tgt_q; state_d = FETCH; end
        end
        FULL: begin
          if (!Stall && skid_vld) begin
            ifid_d      = skid_q;
            valid_d     = 1'b1;
            skid_unload = 1'b1;
            state_d     = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      valid_q <= 1'b0;
      ifid_q  <= '{instr: NOP_INSTR, pc4: 32'h0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem.ImemReq  = ~Reset & (state_q != FULL);
  assign imem.ImemAddr = pc_q;
  assign IfIdValid     = valid_q;
  assign IfIdInstr     = ifid_q.instr;
  assign IfIdPCPlus4   = ifid_q.pc4;
  assign Imm16         = ifid_q.instr[15:0];
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed cycle table plus randomized run
// scored against an instruction-stream model (sequential PC, redirect, reset).
module tb_instruction_fetch_stage;
  import fetch_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Redirect;
  logic [31:0] RedirectPC;
  logic        IfIdValid;
  logic [31:0] IfIdInstr, IfIdPCPlus4;
  logic [15:0] Imm16;

  instruction_fetch_stage_if imem ();

  instruction_fetch_stage dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .imem        (imem),
    .IfIdValid   (IfIdValid),
    .IfIdInstr   (IfIdInstr),
    .IfIdPCPlus4 (IfIdPCPlus4),
    .Imm16       (Imm16)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr, pc4;
  } vec_t;

  function automatic vec_t mk(input logic rst, stall, redir, input logic [31:0] rpc,
                              input logic ack, input logic [31:0] data,
                              input logic req, input logic [31:0] addr, input logic v,
                              input logic [31:0] instr, pc4);
    vec_t r;
    r.rst = rst; r.stall = stall; r.redir = redir; r.rpc = rpc; r.ack = ack; r.data = data;
    r.req = req; r.addr = addr; r.v = v; r.instr = instr; r.pc4 = pc4;
    return r;
  endfunction

  localparam int NV = 28;
  vec_t tbl[NV];

  logic [31:0] exp_pc, hold_instr, hold_pc4, pend_addr;
  logic        rst_p, redir_p, hold_p, pend_p;
  int          lat, consumed;

  initial begin
    //             rst st rd rpc           ack data           req addr          v  instr          pc4
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        1, 32'h2008_0005, 1, 32'h0,        0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        1, 32'h3409_FFFF, 1, 32'h4,        1, 32'h2008_0005, 32'h4);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h8,        1, 32'h3409_FFFF, 32'h8);
    tbl[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h8,        0, 32'h3409_FFFF, 32'h8);
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h8,        0, 32'h3409_FFFF, 32'h8);
    tbl[6]  = mk(0, 0, 0, 32'h0,        1, 32'h2400_0010, 1, 32'h8,        0, 32'h3409_FFFF, 32'h8);
    tbl[7]  = mk(0, 1, 0, 32'h0,        1, 32'h2400_0020, 1, 32'hC,        1, 32'h2400_0010, 32'hC);
    tbl[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h10,       1, 32'h2400_0010, 32'hC);
    tbl[9]  = mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h10,       1, 32'h2400_0010, 32'hC);
    tbl[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h10,       1, 32'h2400_0010, 32'hC);
    tbl[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h10,       1, 32'h2400_0010, 32'hC);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h10,       1, 32'h2400_0020, 32'h10);
    tbl[13] = mk(0, 0, 1, 32'h103,      0, 32'h0,         1, 32'h10,       0, 32'h2400_0020, 32'h10);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h10,       0, 32'h2400_0020, 32'h10);
    tbl[15] = mk(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h10,       0, 32'h2400_0020, 32'h10);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h100,      0, 32'h2400_0020, 32'h10);
    tbl[17] = mk(0, 0, 0, 32'h0,        1, 32'h2400_0100, 1, 32'h100,      0, 32'h2400_0020, 32'h10);
    tbl[18] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_BAD0, 1, 32'h104,    1, 32'h2400_0100, 32'h104);
    tbl[19] = mk(0, 0, 0, 32'h0,        1, 32'h2400_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h2400_0100, 32'h104);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, 32'h2400_0000, 1, 32'h0,        1, 32'h2400_FFFC, 32'h0);
    tbl[21] = mk(0, 0, 1, 32'h200,      0, 32'h0,         1, 32'h4,        1, 32'h2400_0000, 32'h4);
    tbl[22] = mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h4,        0, 32'h2400_0000, 32'h4);
    tbl[23] = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0);
    tbl[24] = mk(0, 0, 0, 32'h0,        1, 32'h2400_0A00, 1, 32'h0,        0, 32'h0,        32'h0);
    tbl[25] = mk(0, 1, 0, 32'h0,        1, 32'h2400_0A04, 1, 32'h4,        1, 32'h2400_0A00, 32'h4);
    tbl[26] = mk(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 32'h2400_0A00, 32'h4);
    tbl[27] = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,        32'h0);

    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    imem.ImemAck = 1'b0; imem.ImemData = 32'h0;
    repeat (2) @(posedge Clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      Reset = tbl[i].rst; Stall = tbl[i].stall; Redirect = tbl[i].redir;
      RedirectPC = tbl[i].rpc; imem.ImemAck = tbl[i].ack; imem.ImemData = tbl[i].data;
      #1;
      chk($sformatf("v%0d.req", i),   {31'h0, imem.ImemReq}, {31'h0, tbl[i].req});
      chk($sformatf("v%0d.addr", i),  imem.ImemAddr, tbl[i].addr);
      chk($sformatf("v%0d.valid", i), {31'h0, IfIdValid}, {31'h0, tbl[i].v});
      chk($sformatf("v%0d.instr", i), IfIdInstr, tbl[i].instr);
      chk($sformatf("v%0d.pc4", i),   IfIdPCPlus4, tbl[i].pc4);
      chk($sformatf("v%0d.imm16", i), {16'h0, Imm16}, {16'h0, tbl[i].instr[15:0]});
    end

    // Randomized run: every consumed instruction must be the next word of the
    // program stream, which restarts at the redirect target or at reset.
    @(negedge Clk);
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; imem.ImemAck = 1'b0;
    @(posedge Clk);
    exp_pc = 32'h0; rst_p = 1'b1; redir_p = 1'b0; hold_p = 1'b0; pend_p = 1'b0;
    hold_instr = 32'h0; hold_pc4 = 32'h0; pend_addr = 32'h0;
    lat = $urandom_range(0, 3); consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if (rst_p) begin
        chk("rnd.rst_valid", {31'h0, IfIdValid}, 32'h0);
        chk("rnd.rst_instr", IfIdInstr, 32'h0);
        chk("rnd.rst_pc4", IfIdPCPlus4, 32'h0);
      end else if (redir_p) begin
        chk("rnd.flush_valid", {31'h0, IfIdValid}, 32'h0);
      end else if (hold_p) begin
        chk("rnd.hold_valid", {31'h0, IfIdValid}, 32'h1);
        chk("rnd.hold_instr", IfIdInstr, hold_instr);
        chk("rnd.hold_pc4", IfIdPCPlus4, hold_pc4);
      end
      if (pend_p && imem.ImemReq) chk("rnd.addr_stable", imem.ImemAddr, pend_addr);
      if (IfIdValid) chk("rnd.imm16", {16'h0, Imm16}, {16'h0, IfIdInstr[15:0]});

      Reset    = ($urandom_range(0, 299) == 0);
      Stall    = ($urandom_range(0, 2) == 0);
      Redirect = ($urandom_range(0, 24) == 0);
      RedirectPC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                               : $urandom;
      #1;
      if (Reset) chk("rnd.req_in_reset", {31'h0, imem.ImemReq}, 32'h0);
      if (imem.ImemReq && lat == 0) begin
        imem.ImemAck = 1'b1; imem.ImemData = memf(imem.ImemAddr);
        lat = $urandom_range(0, 3);
      end else begin
        imem.ImemAck = 1'b0; imem.ImemData = $urandom;
        if (imem.ImemReq) lat--;
        else lat = $urandom_range(0, 3);
      end
      #1;
      rst_p      = Reset;
      redir_p    = Redirect & ~Reset;
      hold_p     = IfIdValid & Stall & ~Redirect & ~Reset;
      hold_instr = IfIdInstr;
      hold_pc4   = IfIdPCPlus4;
      pend_p     = imem.ImemReq & ~imem.ImemAck & ~Reset;
      pend_addr  = imem.ImemAddr;
      if (Reset) exp_pc = 32'h0;
      else if (Redirect) exp_pc = RedirectPC & ~32'h3;
      else if (IfIdValid && !Stall) begin
        chk("rnd.stream_instr", IfIdInstr, memf(exp_pc));
        chk("rnd.stream_pc4", IfIdPCPlus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    @(negedge Clk);
    imem.ImemAck = 1'b0; Stall = 1'b0; Redirect = 1'b0; Reset = 1'b0;
    tests++;
    if (consumed < 200) begin
      fails++;
      $display("FAIL rnd.throughput: got %0d instructions expected at least 200", consumed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
